array_stream_loader: RTL and testbench
======================================

Name: array_stream_loader

Overview:
- Writer-side companion to the array-indexing entities: fills a 3-D register array of NBITS-wide words from a valid/ready word stream in row-major order.
- Exposes the whole array on an unpacked output port and provides a registered random-access read port.
- Sits between a streaming producer (DMA or testbench driver) and combinational consumers that slice and index the array.

Parameters:
- D0, 3, outermost dimension size
- D1, 2, middle dimension size
- D2, 4, innermost dimension size
- NBITS, 16, element width in bits

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  begin a load, sampled in IDLE or DONE only
- IN_DATA  in  NBITS  stream word
- IN_VALID  in  1  stream word valid
- IN_READY  out  1  loader accepts a word this cycle
- BUSY  out  1  high in LOAD
- DONE  out  1  high in DONE state
- RD_I  in  2  read index, dimension 0
- RD_J  in  1  read index, dimension 1
- RD_K  in  2  read index, dimension 2
- RD_DATA  out  NBITS  registered read data
- ARR  out  NBITS x [D0][D1][D2]  live array contents
- CKSUM  out  NBITS  running checksum (see Optional Feature)

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; IN_READY=0, BUSY=0, DONE=0, RD_DATA=0, CKSUM=0.
  - Counters i, j, k = 0.
  - ARR[i][j][k] = NBITS'(i*D1*D2 + j*D2 + k), i.e. values 0..23 for the default parameters.
- FSM states: IDLE, LOAD, DONE.
  - IDLE, START=1 -> LOAD; counters cleared; CKSUM cleared.
  - LOAD: IN_READY=1, BUSY=1. An accept occurs on IN_VALID&&IN_READY at the clock edge: ARR[i][j][k] <= IN_DATA, then the counters advance.
  - LOAD, last element accepted (i=D0-1, j=D1-1, k=D2-1) -> DONE; IN_READY drops on the following cycle.
  - DONE: DONE=1, holds until START=1 -> LOAD with the counters cleared.
  - START is ignored while in LOAD.
- Counter advance:
  - k increments.
  - k wrap (D2-1 -> 0) increments j.
  - j wrap (D1-1 -> 0) increments i.
  - i wrap occurs only on the final accept; counters then hold at 0.
- IN_VALID low in LOAD: no write, counters hold, no timeout.
- Unwritten elements keep their previous value: reset pattern or the prior load.
- Read port:
  - RD_DATA <= ARR[RD_I][RD_J][RD_K] one cycle after the indices are presented, in every state.
  - Out-of-range index (RD_I >= D0 or RD_K >= D2) returns 0.
  - Read and write to the same element in the same cycle returns the old value; the new value is visible the next cycle.
- ARR reflects a write one cycle after the accept edge.
- Reset asserted mid-load: the array returns to the reset pattern immediately and the FSM goes to IDLE. A partial load is discarded.
- Index widths are fixed to $clog2 of the dimension, minimum 1 bit.

Optional Feature:
- Macro: ARRAY_STREAM_LOADER_CKSUM_EN.
- Defined:
  - CKSUM accumulates the modulo-2^NBITS sum of all words accepted since the last START.
  - Updates one cycle after each accept and holds in DONE.
- Undefined:
  - The CKSUM port exists but is tied to 0.
  - No accumulator logic is synthesized.

Test Plan:
1. Reset, no START -> ARR[1][0][1]=9, ARR[2][1][2]=22; read (0,1,3) -> RD_DATA=7 after 1 cycle; IN_READY=0.
2. START, then 24 back-to-back words 100..123 -> ARR[1][0][1]=109, ARR[2][1][3]=123; DONE=1 exactly one cycle after the 24th accept; IN_READY=0 in DONE.
3. Load with IN_VALID toggled every other cycle, words 0xFFFF for all 24 -> load completes after 24 accepts; with CKSUM_EN, CKSUM=0xFFE8 (24*0xFFFF mod 2^16).
4. Reset pulse after 10 accepts -> ARR restored to 0..23; state IDLE; IN_READY=0 asynchronously; a new START reloads from (0,0,0).
5. Read (1,1,2) in the same cycle as the write of 0xABCD to it -> RD_DATA = old value 14, then 0xABCD on the next read.
6. START asserted mid-LOAD and in IDLE; RD_I=3 -> START in LOAD ignored (counters continue); RD_DATA=0 for the out-of-range index.

Source files
------------

// File: rtl/array_stream_loader.sv
// Streams NBITS-wide words into a D0 x D1 x D2 register array in row-major order and offers a registered read port.
// Define ARRAY_STREAM_LOADER_CKSUM_EN to add a running modulo-2^NBITS checksum of the accepted words.
module array_stream_loader #(
  parameter int D0    = 3,
  parameter int D1    = 2,
  parameter int D2    = 4,
  parameter int NBITS = 16,
  localparam int IW   = (D0 > 1) ? $clog2(D0) : 1,
  localparam int JW   = (D1 > 1) ? $clog2(D1) : 1,
  localparam int KW   = (D2 > 1) ? $clog2(D2) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  input  logic [IW-1:0]    rd_i,
  input  logic [JW-1:0]    rd_j,
  input  logic [KW-1:0]    rd_k,
  output logic [NBITS-1:0] rd_data,
  output logic [NBITS-1:0] arr [D0][D1][D2],
  output logic [NBITS-1:0] cksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [IW-1:0] I_LAST = IW'(D0 - 1);
  localparam logic [JW-1:0] J_LAST = JW'(D1 - 1);
  localparam logic [KW-1:0] K_LAST = KW'(D2 - 1);

  state_t        state;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic          accept;
  logic          last_elem;
  logic          rd_oob;
  logic          restart;

  assign accept    = in_valid && in_ready;
  assign last_elem = (i == I_LAST) && (j == J_LAST) && (k == K_LAST);
  assign restart   = start && (state != LOAD);
  assign rd_oob    = ({1'b0, rd_i} >= (IW+1)'(D0)) ||
                     ({1'b0, rd_j} >= (JW+1)'(D1)) ||
                     ({1'b0, rd_k} >= (KW+1)'(D2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
          end
        end
        LOAD: begin
          // START is deliberately not examined here; only accepts move the load forward.
          if (accept) begin
            if (last_elem) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              i        <= '0;
              j        <= '0;
              k        <= '0;
            end else if (k == K_LAST) begin
              k <= '0;
              if (j == J_LAST) begin
                j <= '0;
                i <= i + 1'b1;
              end else begin
                j <= j + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Reset loads a recognisable ramp so consumers see defined contents before any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < D0; a++)
        for (int b = 0; b < D1; b++)
          for (int c = 0; c < D2; c++)
            arr[a][b][c] <= NBITS'(a*D1*D2 + b*D2 + c);
      rd_data <= '0;
    end else begin
      if (accept)
        arr[i][j][k] <= in_data;
      rd_data <= rd_oob ? '0 : arr[rd_i][rd_j][rd_k];
    end
  end

`ifdef ARRAY_STREAM_LOADER_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cksum <= '0;
    else if (restart)
      cksum <= '0;
    else if (accept)
      cksum <= cksum + in_data;
  end
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_array_stream_loader.sv
// Self-checking bench for array_stream_loader: reset pattern, loads, async reset, read hazards and START handling.
module tb_array_stream_loader;

  localparam int N = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [1:0]  rd_i = '0;
  logic        rd_j = 1'b0;
  logic [1:0]  rd_k = '0;
  logic [15:0] rd_data;
  logic [15:0] arr [3][2][4];
  logic [15:0] cksum;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_arr [N];
  logic [15:0] sum_model;
  int          next_idx;
  logic [15:0] rd_q [$];

  typedef struct {
    logic [1:0]  ri;
    logic        rj;
    logic [1:0]  rk;
    logic [15:0] expv;
  } rd_vec_t;

  rd_vec_t vecs [6];

  array_stream_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done),
    .rd_i(rd_i), .rd_j(rd_j), .rd_k(rd_k), .rd_data(rd_data),
    .arr(arr), .cksum(cksum)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] arrAt(int n);
    return arr[2'(n / 8)][1'((n / 4) % 2)][2'(n % 4)];
  endfunction

  function automatic logic [15:0] expCksum();
`ifdef ARRAY_STREAM_LOADER_CKSUM_EN
    return sum_model;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One clock of stimulus; any read queued by presentRead is scored on the resulting edge.
  task automatic applyStimulus(input logic st, input logic vld, input logic [15:0] d);
    start    = st;
    in_valid = vld;
    in_data  = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    if (rd_q.size() > 0)
      checkOutput("rd_data", rd_data, rd_q.pop_front());
  endtask

  task automatic presentRead(input logic [1:0] ri, input logic rj, input logic [1:0] rk, input logic [15:0] e);
    rd_i = ri;
    rd_j = rj;
    rd_k = rk;
    rd_q.push_back(e);
  endtask

  task automatic acceptWord(input logic [15:0] d, input logic st);
    checkOutput("in_ready_load", 16'(in_ready), 16'd1);
    applyStimulus(st, 1'b1, d);
    exp_arr[next_idx] = d;
    sum_model += d;
    checkOutput("arr_write", arrAt(next_idx), d);
    next_idx++;
  endtask

  task automatic checkArray(input string name);
    for (int n = 0; n < N; n++)
      checkOutput(name, arrAt(n), exp_arr[n]);
  endtask

  task automatic resetModel();
    for (int n = 0; n < N; n++)
      exp_arr[n] = 16'(n);
    sum_model = '0;
    next_idx  = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{2'd0, 1'b1, 2'd3, 16'd7};
    vecs[1] = '{2'd1, 1'b0, 2'd1, 16'd9};
    vecs[2] = '{2'd2, 1'b1, 2'd2, 16'd22};
    vecs[3] = '{2'd3, 1'b0, 2'd0, 16'd0};
    vecs[4] = '{2'd2, 1'b1, 2'd3, 16'd23};
    vecs[5] = '{2'd0, 1'b0, 2'd0, 16'd0};
    resetModel();

    // Reset state and table-driven reads of the reset ramp
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 16'(in_ready), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_rd_data", rd_data, 16'd0);
    checkOutput("rst_cksum", cksum, 16'd0);
    rst_n = 1'b1;
    checkOutput("rst_arr_1_0_1", arr[1][0][1], 16'd9);
    checkOutput("rst_arr_2_1_2", arr[2][1][2], 16'd22);
    checkArray("rst_arr");
    for (int v = 0; v < 6; v++) begin
      presentRead(vecs[v].ri, vecs[v].rj, vecs[v].rk, vecs[v].expv);
      applyStimulus(1'b0, 1'b0, 16'h0);
    end
    checkOutput("idle_in_ready", 16'(in_ready), 16'd0);

    // Back-to-back load of 100..123
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("load_busy", 16'(busy), 16'd1);
    checkOutput("load_done", 16'(done), 16'd0);
    sum_model = '0;
    next_idx  = 0;
    for (int n = 0; n < N; n++) begin
      acceptWord(16'(100 + n), 1'b0);
      checkOutput("done_timing", 16'(done), 16'(n == N - 1));
    end
    checkOutput("done_in_ready", 16'(in_ready), 16'd0);
    checkOutput("done_busy", 16'(busy), 16'd0);
    checkOutput("arr_1_0_1", arr[1][0][1], 16'd109);
    checkOutput("arr_2_1_3", arr[2][1][3], 16'd123);
    checkArray("load1_arr");
    checkOutput("load1_cksum", cksum, expCksum());
    applyStimulus(1'b0, 1'b1, 16'h5555);
    checkOutput("done_hold", 16'(done), 16'd1);
    checkOutput("done_hold_ready", 16'(in_ready), 16'd0);
    checkArray("done_no_write");

    // Throttled load of 0xFFFF with garbage on idle cycles
    applyStimulus(1'b1, 1'b0, 16'h0);
    sum_model = '0;
    next_idx  = 0;
    checkOutput("reload_done", 16'(done), 16'd0);
    for (int c = 0; c < 2 * N; c++) begin
      if (c % 2 == 0)
        acceptWord(16'hFFFF, 1'b0);
      else
        applyStimulus(1'b0, 1'b0, 16'h1234);
      checkOutput("throttle_done", 16'(done), 16'(next_idx == N));
    end
    checkArray("throttle_arr");
    checkOutput("throttle_cksum", cksum, expCksum());
`ifdef ARRAY_STREAM_LOADER_CKSUM_EN
    checkOutput("cksum_ffe8", cksum, 16'hFFE8);
`endif

    // Asynchronous reset after 10 accepts
    applyStimulus(1'b1, 1'b0, 16'h0);
    sum_model = '0;
    next_idx  = 0;
    for (int n = 0; n < 10; n++)
      acceptWord(16'(16'h0200 + n), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("async_in_ready", 16'(in_ready), 16'd0);
    checkOutput("async_busy", 16'(busy), 16'd0);
    checkOutput("async_arr_0_0_0", arr[0][0][0], 16'd0);
    checkOutput("async_arr_1_0_1", arr[1][0][1], 16'd9);
    checkArray("async_arr");
    checkOutput("async_cksum", cksum, 16'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h7777);
    checkOutput("post_rst_ready", 16'(in_ready), 16'd0);
    checkArray("post_rst_no_write");

    // Fresh load restarts at (0,0,0)
    applyStimulus(1'b1, 1'b0, 16'h0);
    for (int n = 0; n < 3; n++)
      acceptWord(16'(16'h0300 + n), 1'b0);
    checkOutput("restart_untouched", arr[0][0][3], 16'd3);
    for (int n = 3; n < 14; n++)
      acceptWord(16'(16'h0300 + n), 1'b0);

    // Read-during-write of (1,1,2) returns old value, then new
    presentRead(2'd1, 1'b1, 2'd2, 16'd14);
    acceptWord(16'hABCD, 1'b0);
    presentRead(2'd1, 1'b1, 2'd2, 16'hABCD);
    applyStimulus(1'b0, 1'b0, 16'h0);

    // START mid-load is ignored; out-of-range reads return zero
    presentRead(2'd3, 1'b0, 2'd0, 16'd0);
    acceptWord(16'h040F, 1'b1);
    for (int n = 16; n < N; n++) begin
      presentRead(2'd3, 1'(n % 2), 2'(n % 4), 16'd0);
      acceptWord(16'(16'h0400 + n), 1'b0);
    end
    checkOutput("final_done", 16'(done), 16'd1);
    checkArray("final_arr");
    checkOutput("final_cksum", cksum, expCksum());

    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("restart_busy", 16'(busy), 16'd1);
    checkOutput("restart_cksum", cksum, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
